// File: rtl/issue_pkg.sv
// Shared types for the dual-issue queue and its pair hazard checker.
package issue_pkg;
  localparam int OPCODE_W  = 7;
  localparam int REG_W     = 5;
  localparam int OPERAND_W = 16;

  localparam logic FORMAT_19B = 1'b0;
  localparam logic FORMAT_30B = 1'b1;

  // 30-bit queue entry; the field order matches the bench's packed compare.
  typedef struct packed {
    logic                 fmt;
    logic                 isBranch;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_W-1:0]     dst;
    logic [OPERAND_W-1:0] operand;
  } entry_t;

  function automatic logic reads_src(input entry_t e);
    return (e.fmt == FORMAT_19B) && (e.fmt != FORMAT_30B);
  endfunction
endpackage

// File: rtl/pair_hazard_check.sv
// Decides whether entry B may issue in the same group as the older entry A.
module pair_hazard_check
  import issue_pkg::*;
(
  input  entry_t a_i,
  input  entry_t b_i,
  output logic   coIssue_o
);
  logic w_hazard;
  logic w_unused;

  // A branch always closes the group; B must not touch A's register.
  assign w_hazard = a_i.isBranch
                 || (b_i.dst == a_i.dst)
                 || (reads_src(b_i) && (b_i.operand[REG_W-1:0] == a_i.dst));

  assign coIssue_o = ~w_hazard;
  assign w_unused  = ^{a_i.fmt, a_i.opcode, a_i.operand, b_i.isBranch,
                       b_i.opcode, b_i.operand[OPERAND_W-1:REG_W]};
endmodule

// File: rtl/dual_issue_queue.sv
// In-order circular queue taking up to two instructions per cycle and
// issuing up to two independent ones per cycle to execute.
module dual_issue_queue
  import issue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int PTR_W       = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flushBack_i,
  input  logic                 enable_i1,
  input  logic                 enable_i2,
  input  logic                 isBranch_i1,
  input  logic                 isBranch_i2,
  input  logic                 instructionFormat_i1,
  input  logic                 instructionFormat_i2,
  input  logic [6:0]           opcode_i1,
  input  logic [6:0]           opcode_i2,
  input  logic [4:0]           reg_i1,
  input  logic [4:0]           reg_i2,
  input  logic [15:0]          operand_i1,
  input  logic [15:0]          operand_i2,
  input  logic                 ready_i,
  output logic                 stall_o,
  output logic                 issueValid_o1,
  output logic                 issueValid_o2,
  output logic                 isBranch_o1,
  output logic                 isBranch_o2,
  output logic                 instructionFormat_o1,
  output logic                 instructionFormat_o2,
  output logic [6:0]           opcode_o1,
  output logic [6:0]           opcode_o2,
  output logic [4:0]           reg_o1,
  output logic [4:0]           reg_o2,
  output logic [15:0]          operand_o1,
  output logic [15:0]          operand_o2,
  output logic [PTR_W:0]       queueCount_o
);
  localparam logic [PTR_W:0] STALL_TH = (PTR_W+1)'(QUEUE_DEPTH - 2);

  entry_t           r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_stall, r_v1, r_v2;
  entry_t           r_o1, r_o2;

  entry_t           w_in1, w_in2, w_a, w_b;
  logic             w_wr1, w_wr2, w_adv, w_coissue, w_clear;
  logic [1:0]       w_enq, w_deq;
  logic [PTR_W-1:0] w_wptr2;
  logic [PTR_W:0]   w_count_next;

  assign w_in1 = '{fmt: instructionFormat_i1, isBranch: isBranch_i1,
                   opcode: opcode_i1, dst: reg_i1, operand: operand_i1};
  assign w_in2 = '{fmt: instructionFormat_i2, isBranch: isBranch_i2,
                   opcode: opcode_i2, dst: reg_i2, operand: operand_i2};

  assign w_clear = reset_i | flushBack_i;
  assign w_wr1   = enable_i1 & ~r_stall;
  assign w_wr2   = enable_i2 & ~r_stall;
  assign w_enq   = {1'b0, w_wr1} + {1'b0, w_wr2};
  assign w_wptr2 = w_wr1 ? r_tail + 1'b1 : r_tail;

  // Issue group is drawn only from entries present at the start of the cycle.
  assign w_a   = r_mem[r_head];
  assign w_b   = r_mem[r_head + 1'b1];
  assign w_adv = ~r_v1 | ready_i;

  pair_hazard_check u_hazard (
    .a_i       (w_a),
    .b_i       (w_b),
    .coIssue_o (w_coissue)
  );

  always_comb begin
    w_deq = 2'd0;
    if (w_adv && (r_count != '0))
      w_deq = ((r_count[PTR_W:1] != '0) && w_coissue) ? 2'd2 : 2'd1;
  end

  assign w_count_next = r_count + {{(PTR_W-1){1'b0}}, w_enq}
                                - {{(PTR_W-1){1'b0}}, w_deq};

  always_ff @(posedge clock_i) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_o1    <= '0;
      r_o2    <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= w_count_next;
      // Stall while fewer than two entries would be free next cycle.
      r_stall <= w_count_next > STALL_TH;
      if (w_adv) begin
        r_v1 <= (r_count != '0);
        r_v2 <= (w_deq == 2'd2);
        if (r_count != '0) r_o1 <= w_a;
        if (w_deq == 2'd2) r_o2 <= w_b;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!w_clear) begin
      if (w_wr1) r_mem[r_tail]  <= w_in1;
      if (w_wr2) r_mem[w_wptr2] <= w_in2;
    end
  end

  assign stall_o              = r_stall;
  assign queueCount_o         = r_count;
  assign issueValid_o1        = r_v1;
  assign issueValid_o2        = r_v2;
  assign isBranch_o1          = r_o1.isBranch;
  assign isBranch_o2          = r_o2.isBranch;
  assign instructionFormat_o1 = r_o1.fmt;
  assign instructionFormat_o2 = r_o2.fmt;
  assign opcode_o1            = r_o1.opcode;
  assign opcode_o2            = r_o2.opcode;
  assign reg_o1               = r_o1.dst;
  assign reg_o2               = r_o2.dst;
  assign operand_o1           = r_o1.operand;
  assign operand_o2           = r_o2.operand;
endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Stage directly downstream of the bundle parser.
- Accepts up to two parsed instructions per cycle, buffers them in order in a circular queue, and issues up to two per cycle to execute.
- Co-issues the second instruction only when it is independent of the first.
- Drives the stall back to the parser and the fetch front end.

Parameters:
QUEUE_DEPTH, 8, number of entries; power of two, minimum 4.
PTR_W, 3, log2(QUEUE_DEPTH); sizes the head and tail pointers.

Ports:
clock_i  in  1  single clock, rising edge.
reset_i  in  1  synchronous, active-high reset.
flushBack_i  in  1  pipeline flush; empties the queue and invalidates the outputs.
enable_i1 / enable_i2  in  1  slot valid from the parser.
isBranch_i1 / isBranch_i2  in  1  branch bit.
instructionFormat_i1 / _i2  in  1  0 = 19b format (operand[4:0] is a source register); 1 = 30b format (operand is a 16b immediate).
opcode_i1 / _i2  in  7  opcode.
reg_i1 / reg_i2  in  5  destination register; also read as a source.
operand_i1 / operand_i2  in  16  operand field.
ready_i  in  1  execute stage can accept an issue group this cycle.
stall_o  out  1  upstream must hold; inputs are ignored while high.
issueValid_o1 / issueValid_o2  out  1  issue slot valid.
isBranch_o1/_o2, instructionFormat_o1/_o2, opcode_o1/_o2 (7), reg_o1/_o2 (5), operand_o1/_o2 (16)  out  issued instruction fields.
queueCount_o  out  PTR_W+1  current occupancy, for debug and perf counters.

Behaviour:
- Reset, synchronous on reset_i:
  - head = tail = 0, count = 0, stall_o = 0.
  - issueValid_o1 = issueValid_o2 = 0.
  - All issued field outputs = 0.
- flushBack_i: same effect as reset, except that reset_i has priority. Any enqueue or issue in the same cycle is discarded.
- Enqueue, only when stall_o == 0:
  - enable_i1 writes slot1 at tail.
  - enable_i2 writes slot2 at tail+1 if slot1 was written, otherwise at tail.
  - enq = enable_i1 + enable_i2 (0..2). Pointers wrap modulo QUEUE_DEPTH.
  - When stall_o == 1, inputs are dropped. Upstream holds them; this block neither retries nor buffers them.
- Issue:
  - Output registers advance when (issueValid_o1 == 0 || ready_i == 1); otherwise they hold all values.
  - On advance, the issue group is formed from entries present at the start of the cycle only. There is no bypass of same-cycle enqueues.
    - count == 0 -> issueValid_o1 = issueValid_o2 = 0.
    - count >= 1 -> head entry goes to slot 1, issueValid_o1 = 1.
    - Slot 2 takes head+1 only if count >= 2 and there is no hazard; otherwise issueValid_o2 = 0.
  - Hazard (entry A = head, entry B = head+1):
    - A.isBranch == 1, or
    - B.reg == A.reg, or
    - B.instructionFormat == 0 and B.operand[4:0] == A.reg.
  - deq = number of entries loaded into the output registers (0..2).
- Latency: an instruction enqueued at edge N is visible on the outputs after edge N+1 at the earliest. Order is strictly preserved.
- Count update: count_next = count + enq - deq. Simultaneous enqueue and dequeue is legal at any occupancy, including full.
- stall_o is registered: stall_o <= (count_next > QUEUE_DEPTH-2). Two free entries are therefore guaranteed whenever stall_o is low, so overflow cannot occur.
- Empty queue with ready_i high: outputs go invalid; the field outputs hold their last values.
- Hazard evaluation ignores the valid bits of unoccupied entries, because it is gated by count.
- queueCount_o = count register.

Decomposition:
- Shared package `issue_pkg`:
  - Queue entry struct, 30b: format, isBranch, opcode[6:0], reg[4:0], operand[15:0].
  - Width constants: OPCODE_W = 7, REG_W = 5, OPERAND_W = 16.
  - FORMAT_19B = 0, FORMAT_30B = 1.
- One sub-module, `pair_hazard_check`: combinational; takes two entries and returns the co-issue permission. It is reused later by the scoreboard.

Test Plan:
- Single entry: reset, then enable_i1 = 1 (opcode 0x05, reg 3, format 1) with ready_i = 1 -> issueValid_o1 = 1 two edges later, opcode_o1 = 0x05, issueValid_o2 = 0.
- Co-issue: enqueue A (reg 3) and B (reg 4, format 0, operand 0x0007) -> both slots valid in the same cycle. Repeat with B.operand = 0x0003 -> A issues alone, then B the next cycle.
- Branch split: A.isBranch = 1 with an independent B -> A issues alone, B issues one cycle later.
- Fill:
  - ready_i = 0 with 2 instructions/cycle -> stall_o rises when count_next reaches 7 or more; queueCount_o never exceeds 8; inputs presented while stalled are not enqueued.
  - Raise ready_i -> stall_o drops once count_next <= 6.
  - The issue sequence exactly matches enqueue order across pointer wrap.
- Flush mid-stream: 5 entries queued and outputs valid, assert flushBack_i for one cycle -> next cycle issueValid_o1/_o2 = 0, queueCount_o = 0, stall_o = 0.
- Reset priority: assert reset_i and flushBack_i together while enqueuing -> all outputs at reset values, no entry retained.
